// File: rtl/ifetch_stage_pkg.sv
// ifetch_stage_pkg: shared widths, NOP encoding and IF state encodings for the fetch stage
package ifetch_stage_pkg;
  localparam int PC_SIZE = 32;
  localparam int INSTR_SIZE = 32;
  localparam logic [INSTR_SIZE-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  typedef enum logic [1:0] {
    IF_ST_REQ  = 2'd0,
    IF_ST_WAIT = 2'd1,
    IF_ST_HOLD = 2'd2
  } if_state_e;
endpackage

// File: rtl/ifetch_stage_ifid_reg.sv
// ifetch_stage_ifid_reg: IF/ID pipeline register with load, flush-to-NOP and drain controls
module ifetch_stage_ifid_reg
  import ifetch_stage_pkg::*;
#(
  parameter logic [PC_SIZE-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic                  drain_i,
  input  logic [INSTR_SIZE-1:0] instr_i,
  input  logic [PC_SIZE-1:0]    pc_i,
  output logic                  valid_o,
  output logic [INSTR_SIZE-1:0] instr_o,
  output logic [PC_SIZE-1:0]    pc_o
);
  logic                  valid_q, valid_d;
  logic [INSTR_SIZE-1:0] instr_q, instr_d;
  logic [PC_SIZE-1:0]    pc_q, pc_d;
  // flush wins over load; pc is left untouched by a flush
  always_comb begin
    valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
    instr_d = flush_i ? NOP_INSTR : load_i ? instr_i : instr_q;
    pc_d    = (!flush_i && load_i) ? pc_i : pc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;
endmodule

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC register, single-outstanding imem fetch FSM and IF/ID loading with
// redirect kill and ID backpressure.
module ifetch_stage
  import ifetch_stage_pkg::*;
#(
  parameter logic [PC_SIZE-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_SIZE-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [PC_SIZE-1:0]    pc_o,
  output logic [INSTR_SIZE-1:0] instr_o,
  output logic                  instr_vld_o,
  input  logic [PC_SIZE-1:0]    pc_next_i,
  input  logic                  instr_nop_sel_i,
  output logic                  imem_req_o,
  output logic [PC_SIZE-1:0]    imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [INSTR_SIZE-1:0] imem_rdata_i,
  input  logic                  id_ready_i,
  output logic                  id_valid_o,
  output logic [INSTR_SIZE-1:0] id_instr_o,
  output logic [PC_SIZE-1:0]    id_pc_o
);
  if_state_e             state_q, state_d;
  logic [PC_SIZE-1:0]    pc_q, pc_d;
  logic                  kill_q, kill_d;
  logic [INSTR_SIZE-1:0] hold_q, hold_d;
  logic                  resp, live, accept;
  assign resp        = state_q == IF_ST_WAIT && imem_rvalid_i && !kill_q;
  assign live        = resp || state_q == IF_ST_HOLD;
  assign accept      = live && id_ready_i && !instr_nop_sel_i;
  assign instr_o     = state_q == IF_ST_HOLD ? hold_q : resp ? imem_rdata_i : NOP_INSTR;
  assign instr_vld_o = live;
  assign pc_o        = pc_q;
  assign imem_req_o  = state_q == IF_ST_REQ;
  assign imem_addr_o = pc_q;
  assign pc_d        = (instr_nop_sel_i || accept) ? pc_next_i : pc_q;
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    hold_d  = hold_q;
    unique case (state_q)
      IF_ST_REQ: begin
        if (imem_gnt_i) begin
          state_d = IF_ST_WAIT;
          kill_d  = instr_nop_sel_i;
        end
      end
      IF_ST_WAIT: begin
        if (imem_rvalid_i) begin
          kill_d = 1'b0;
          if (resp && !instr_nop_sel_i && !id_ready_i) begin
            state_d = IF_ST_HOLD;
            hold_d  = imem_rdata_i;
          end else
            state_d = IF_ST_REQ;
        end else
          kill_d = kill_q || instr_nop_sel_i;
      end
      IF_ST_HOLD: state_d = (instr_nop_sel_i || id_ready_i) ? IF_ST_REQ : IF_ST_HOLD;
      default: begin
        state_d = IF_ST_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IF_ST_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      hold_q  <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      hold_q  <= hold_d;
    end
  end
  ifetch_stage_ifid_reg #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .flush_i(instr_nop_sel_i),
    .drain_i(id_ready_i && !accept),
    .instr_i(instr_o),
    .pc_i   (pc_q),
    .valid_o(id_valid_o),
    .instr_o(id_instr_o),
    .pc_o   (id_pc_o)
  );
endmodule
